pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 16 +
 rtl/sat_counter.sv | 33 +++
 rtl/pipe_stage_reg.sv | 93 +++++++++
 tb/tb_pipe_stage_reg.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the stage payload type used across the MIPS core.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [4:0]  EXC_NONE         = 5'd0;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic        bd;
    } stage_payload_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear suppresses the increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush-to-bubble and stall/bubble perf counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned   IW       = 32,
    parameter int unsigned   AW       = 32,
    parameter int unsigned   EW       = 5,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT),
    parameter bit            KEEP_PC  = 1'b1,
    parameter int unsigned   CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic          clr_cnt,
    input  logic          in_valid,
    input  logic [IW-1:0] in_instr,
    input  logic [AW-1:0] in_pc,
    input  logic [EW-1:0] in_exc,
    input  logic          in_bd,
    output logic          out_valid,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic [EW-1:0] out_exc,
    output logic          out_bd,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] bubble_cnt
);

    logic          valid_q;
    logic [IW-1:0] instr_q;
    logic [AW-1:0] pc_q;
    logic [EW-1:0] exc_q;
    logic          bd_q;

    // Priority: reset > flush > hold > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= IW'(NOP_INSTR);
            pc_q    <= RESET_PC;
            exc_q   <= EW'(EXC_NONE);
            bd_q    <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            instr_q <= IW'(NOP_INSTR);
            exc_q   <= EW'(EXC_NONE);
            // Keeping PC/bd on a bubble lets the exception logic recover the EPC.
            pc_q    <= KEEP_PC ? in_pc : '0;
            bd_q    <= KEEP_PC ? in_bd : 1'b0;
        end else if (en) begin
            valid_q <= in_valid;
            instr_q <= in_valid ? in_instr : IW'(NOP_INSTR);
            pc_q    <= in_pc;
            exc_q   <= in_exc;
            bd_q    <= in_bd;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;
    assign out_exc   = exc_q;
    assign out_bd    = bd_q;

    logic stall_inc, bubble_inc;

    // Only a held valid entry is a real stall; holding an empty slot costs nothing.
    assign stall_inc  = !flush && !en && valid_q;
    assign bubble_inc = flush || (en && !in_valid);

    sat_counter #(
        .W(CW)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_cnt),
        .inc  (stall_inc),
        .cnt  (stall_cnt)
    );

    sat_counter #(
        .W(CW)
    ) u_bubble_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_cnt),
        .inc  (bubble_inc),
        .cnt  (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg, plus KEEP_PC=0 and CW=4 corner cases.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, en, flush, clr_cnt;
    logic        in_valid, in_bd;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  in_exc;

    logic        a_valid, a_bd;
    logic [31:0] a_instr, a_pc;
    logic [4:0]  a_exc;
    logic [15:0] a_stall, a_bubble;

    logic        k_valid, k_bd;
    logic [31:0] k_instr, k_pc;
    logic [4:0]  k_exc;
    logic [15:0] k_stall, k_bubble;

    logic        c_valid, c_bd;
    logic [31:0] c_instr, c_pc;
    logic [4:0]  c_exc;
    logic [3:0]  c_stall, c_bubble;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc),
        .in_bd(in_bd), .out_valid(a_valid), .out_instr(a_instr), .out_pc(a_pc),
        .out_exc(a_exc), .out_bd(a_bd), .stall_cnt(a_stall), .bubble_cnt(a_bubble)
    );

    pipe_stage_reg #(.KEEP_PC(1'b0)) dut_k0 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc),
        .in_bd(in_bd), .out_valid(k_valid), .out_instr(k_instr), .out_pc(k_pc),
        .out_exc(k_exc), .out_bd(k_bd), .stall_cnt(k_stall), .bubble_cnt(k_bubble)
    );

    pipe_stage_reg #(.CW(4)) dut_c4 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc),
        .in_bd(in_bd), .out_valid(c_valid), .out_instr(c_instr), .out_pc(c_pc),
        .out_exc(c_exc), .out_bd(c_bd), .stall_cnt(c_stall), .bubble_cnt(c_bubble)
    );

    typedef struct {
        logic        rst, e, fl, clr, iv, ibd;
        logic [31:0] iinstr, ipc;
        logic [4:0]  iexc;
        logic        xv, xbd;
        logic [31:0] xinstr, xpc;
        logic [4:0]  xexc;
        logic [15:0] xstall, xbubble;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic e, input logic fl, input logic clr,
                         input logic iv, input logic [31:0] iinstr, input logic [31:0] ipc,
                         input logic [4:0] iexc, input logic ibd);
        reset = rst; en = e; flush = fl; clr_cnt = clr;
        in_valid = iv; in_instr = iinstr; in_pc = ipc; in_exc = iexc; in_bd = ibd;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, e, fl, clr, iv, input logic [31:0] iinstr,
                                input logic [31:0] ipc, input logic [4:0] iexc, input logic ibd,
                                input logic xv, input logic [31:0] xinstr, input logic [31:0] xpc,
                                input logic [4:0] xexc, input logic xbd,
                                input logic [15:0] xs, input logic [15:0] xb);
        vec_t v;
        v.rst = rst; v.e = e; v.fl = fl; v.clr = clr; v.iv = iv;
        v.iinstr = iinstr; v.ipc = ipc; v.iexc = iexc; v.ibd = ibd;
        v.xv = xv; v.xinstr = xinstr; v.xpc = xpc; v.xexc = xexc; v.xbd = xbd;
        v.xstall = xs; v.xbubble = xb;
        return v;
    endfunction

    initial begin
        //             rst e fl clr iv instr         pc            exc bd | v instr         pc            exc bd  stall bubble
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        5'd0, 0, 0, 32'h0,        32'h3000, 5'd0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 1, 32'h2408_0005, 32'h3004,    5'd0, 0, 1, 32'h2408_0005, 32'h3004, 5'd0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 1, 32'h8C09_0000, 32'h3008,    5'd0, 0, 1, 32'h8C09_0000, 32'h3008, 5'd0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 1, 32'h1111_1111, 32'h300C,    5'd0, 0, 1, 32'h8C09_0000, 32'h3008, 5'd0, 0, 1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 1, 32'h2222_2222, 32'h3010,    5'd0, 0, 1, 32'h8C09_0000, 32'h3008, 5'd0, 0, 2, 0);
        vecs[5]  = mk(0, 0, 0, 0, 1, 32'h3333_3333, 32'h3014,    5'd0, 0, 1, 32'h8C09_0000, 32'h3008, 5'd0, 0, 3, 0);
        vecs[6]  = mk(0, 0, 1, 0, 1, 32'h1234_5678, 32'h300C,    5'd3, 1, 0, 32'h0,        32'h300C, 5'd0, 1, 3, 1);
        vecs[7]  = mk(0, 0, 0, 0, 1, 32'h5555_5555, 32'h3018,    5'd2, 0, 0, 32'h0,        32'h300C, 5'd0, 1, 3, 1);
        vecs[8]  = mk(0, 1, 0, 0, 0, 32'hDEAD_BEEF, 32'h3020,    5'd4, 1, 0, 32'h0,        32'h3020, 5'd4, 1, 3, 2);
        vecs[9]  = mk(0, 1, 0, 0, 1, 32'h0000_0020, 32'h3024,    5'd12, 0, 1, 32'h0000_0020, 32'h3024, 5'd12, 0, 3, 2);
        vecs[10] = mk(0, 0, 0, 0, 0, 32'h0,        32'h3028,     5'd0, 0, 1, 32'h0000_0020, 32'h3024, 5'd12, 0, 4, 2);
        vecs[11] = mk(1, 0, 0, 0, 1, 32'h6666_6666, 32'h302C,    5'd1, 1, 0, 32'h0,        32'h3000, 5'd0, 0, 0, 0);
        vecs[12] = mk(0, 1, 0, 0, 0, 32'h1111_1111, 32'h3040,    5'd0, 0, 0, 32'h0,        32'h3040, 5'd0, 0, 0, 1);
        vecs[13] = mk(0, 1, 0, 1, 0, 32'h0,        32'h3044,     5'd0, 0, 0, 32'h0,        32'h3044, 5'd0, 0, 0, 0);
        vecs[14] = mk(0, 1, 0, 0, 1, 32'h0000_00AA, 32'h3048,    5'd0, 0, 1, 32'h0000_00AA, 32'h3048, 5'd0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 1, 0, 32'h0,        32'h304C,     5'd0, 0, 1, 32'h0000_00AA, 32'h3048, 5'd0, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 32'h0,        32'h3050,     5'd0, 0, 1, 32'h0000_00AA, 32'h3048, 5'd0, 0, 1, 0);

        reset = 1'b0; en = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; in_exc = '0; in_bd = 1'b0;
        #1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst, vecs[i].e, vecs[i].fl, vecs[i].clr, vecs[i].iv,
                  vecs[i].iinstr, vecs[i].ipc, vecs[i].iexc, vecs[i].ibd);
            check($sformatf("v%0d.valid", i), 32'(a_valid), 32'(vecs[i].xv));
            check($sformatf("v%0d.instr", i), a_instr, vecs[i].xinstr);
            check($sformatf("v%0d.pc", i), a_pc, vecs[i].xpc);
            check($sformatf("v%0d.exc", i), 32'(a_exc), 32'(vecs[i].xexc));
            check($sformatf("v%0d.bd", i), 32'(a_bd), 32'(vecs[i].xbd));
            check($sformatf("v%0d.stall", i), 32'(a_stall), 32'(vecs[i].xstall));
            check($sformatf("v%0d.bubble", i), 32'(a_bubble), 32'(vecs[i].xbubble));
        end

        // KEEP_PC=0: flush during a stall drops PC and bd.
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0);
        check("k0.reset_pc", k_pc, 32'h3000);
        drive(0, 1, 0, 0, 1, 32'h2408_0005, 32'h3100, 5'd0, 0);
        drive(0, 0, 0, 0, 1, 32'h0, 32'h3104, 5'd0, 0);
        check("k0.stall_cnt", 32'(k_stall), 32'd1);
        drive(0, 0, 1, 0, 1, 32'h2408_0005, 32'h310C, 5'd7, 1);
        check("k0.valid", 32'(k_valid), 32'd0);
        check("k0.instr", k_instr, 32'h0);
        check("k0.pc", k_pc, 32'h0);
        check("k0.bd", 32'(k_bd), 32'd0);
        check("k0.exc", 32'(k_exc), 32'd0);
        check("k0.stall_keep", 32'(k_stall), 32'd1);
        check("k0.bubble", 32'(k_bubble), 32'd1);
        check("k1.pc", a_pc, 32'h310C);
        check("k1.bd", 32'(a_bd), 32'd1);

        // CW=4: bubble counter saturates at 4'hF, clear wins over a same-edge flush.
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0);
        for (int n = 1; n <= 20; n++) begin
            drive(0, 0, 1, 0, 0, 32'h0, 32'h3200, 5'd0, 0);
            check($sformatf("c4.bubble_%0d", n), 32'(c_bubble), (n > 15) ? 32'd15 : 32'(n));
        end
        drive(0, 0, 1, 1, 0, 32'h0, 32'h3200, 5'd0, 0);
        check("c4.clr_with_flush", 32'(c_bubble), 32'd0);
        drive(0, 0, 1, 0, 0, 32'h0, 32'h3200, 5'd0, 0);
        check("c4.after_clr", 32'(c_bubble), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
